// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external adder (req_* in, add_* to/from adder, rsp_* result out, busy status)
module adder_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_ci,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_co,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_co,
    output logic                  busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_last_q, rr_last_d, rsp_id_q, rsp_id_d, win, idx;
    logic             found;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d, rsp_sum_q, rsp_sum_d;
    logic             add_ci_q, add_ci_d, rsp_valid_q, rsp_valid_d, rsp_co_q, rsp_co_d;
    always_comb begin
        win   = rr_last_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(rr_last_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    assign req_ready = (rst_n && state_q == S_IDLE && found) ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        wait_cnt_d  = wait_cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_ci_d    = add_ci_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_co_d    = rsp_co_q;
        case (state_q)
            S_IDLE: if (found) begin
                add_a_d    = req_a[win*WIDTH +: WIDTH];
                add_b_d    = req_b[win*WIDTH +: WIDTH];
                add_ci_d   = req_ci[win];
                rsp_id_d   = win;
                rr_last_d  = win;
                wait_cnt_d = CW'(ADD_LAT);
                state_d    = S_WAIT;
            end
            S_WAIT: if (wait_cnt_q == '0) begin
                rsp_sum_d   = add_s;
                rsp_co_d    = add_co;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end else begin
                wait_cnt_d = wait_cnt_q - CW'(1);
            end
            S_RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_last_q   <= IDW'(NREQ - 1);
            wait_cnt_q  <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ci_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_co_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            wait_cnt_q  <= wait_cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_ci_q    <= add_ci_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_co_q    <= rsp_co_d;
        end
    end
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_ci    = add_ci_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_co    = rsp_co_q;
    assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: scoreboard bench for adder_share_arbiter with a registered adder model
module tb_adder_share_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ci;
    logic [31:0]  add_a, add_b, add_s, rsp_sum;
    logic         add_ci, add_co, rsp_valid, rsp_co, busy;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  a_v [4];
    logic [31:0]  b_v [4];
    logic         ci_v [4];
    typedef struct packed {logic [1:0] id; logic [32:0] val;} exp_t;
    exp_t sb [$];
    exp_t e;
    int n_cmp = 0;
    int n_fail = 0;

    adder_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_co(rsp_co), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_ci);

    always_comb begin
        req_a  = '0;
        req_b  = '0;
        req_ci = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = a_v[i];
            req_b[i*32 +: 32] = b_v[i];
            req_ci[i]         = ci_v[i];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int id);
        sb.push_back({2'(id), {1'b0, a_v[id]} + {1'b0, b_v[id]} + 33'(ci_v[id])});
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string nm);
        int t;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(nm, 128'(req_ready), 128'(exp));
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'({rsp_id, rsp_co, rsp_sum}), 128'(0) - 1);
            end else begin
                e = sb.pop_front();
                chk("rsp", 128'({rsp_id, rsp_co, rsp_sum}), 128'({e.id, e.val}));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        int t;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
            ci_v[i] = 1'b0;
        end
        req_valid = 4'($urandom);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("reset_ctl", 128'({req_ready, add_ci, rsp_valid, rsp_id, rsp_co, busy}), 128'(0));
            chk("reset_data", 128'({add_a, add_b, rsp_sum}), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) begin
                a_v[i] = $urandom;
                b_v[i] = $urandom;
                ci_v[i] = 1'($urandom);
            end
            req_valid = 4'hF;
            m = 4'b0001 << (k % 4);
            wait_grant(m, "fair_grant");
            push(k % 4);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (6) @(negedge clk);
        a_v[1] = 32'hFFFFFFFF;
        b_v[1] = 32'h00000001;
        ci_v[1] = 1'b0;
        req_valid = 4'b0010;
        wait_grant(4'b0010, "single_grant");
        push(1);
        @(negedge clk);
        req_valid = '0;
        #1 chk("lat_c1", 128'(rsp_valid), 128'(0));
        @(negedge clk);
        #1 chk("lat_c2", 128'(rsp_valid), 128'(0));
        @(negedge clk);
        #1 chk("lat_c3", 128'(rsp_valid), 128'(1));
        chk("single_rsp", 128'({rsp_id, rsp_co, rsp_sum}), 128'({2'd1, 1'b1, 32'h00000000}));
        @(negedge clk);
        a_v[2] = 32'h7FFFFFFF;
        b_v[2] = 32'h00000000;
        ci_v[2] = 1'b1;
        req_valid = 4'b0100;
        wait_grant(4'b0100, "cin_grant");
        push(2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("cin_rsp", 128'({rsp_valid, rsp_id, rsp_co, rsp_sum}), 128'({1'b1, 2'd2, 1'b0, 32'h80000000}));
        @(negedge clk);
        rsp_ready = 1'b0;
        a_v[3] = 32'h12345678;
        b_v[3] = 32'h9ABCDEF0;
        ci_v[3] = 1'b1;
        a_v[0] = 32'hFFFFFFFF;
        b_v[0] = 32'hFFFFFFFF;
        ci_v[0] = 1'b1;
        req_valid = 4'hF;
        wait_grant(4'b1000, "bp_grant");
        push(3);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!rsp_valid && t < 10);
        chk("bp_valid", 128'(rsp_valid), 128'(1));
        repeat (5) begin
            @(negedge clk);
            #1 chk("bp_hold", 128'({rsp_valid, rsp_id, rsp_co, rsp_sum, busy, req_ready}),
                   128'({1'b1, 2'd3, 1'b0, 32'hACF13569, 1'b1, 4'b0000}));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1 chk("bp_drop", 128'({rsp_valid, busy}), 128'(0));
        chk("bp_next_grant", 128'(req_ready), 128'(4'b0001));
        push(0);
        @(negedge clk);
        req_valid = '0;
        #1 chk("bp_busy_after", 128'(busy), 128'(1));
        repeat (6) @(negedge clk);
        req_valid = 4'b1000;
        wait_grant(4'b1000, "rst_mid_grant");
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1 chk("rst_mid_ctl", 128'({req_ready, add_ci, rsp_valid, rsp_id, rsp_co, busy}), 128'(0));
        chk("rst_mid_data", 128'({add_a, add_b, rsp_sum}), 128'(0));
        @(negedge clk);
        #1 chk("rst_mid_hold", 128'({rsp_valid, busy}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1001;
        wait_grant(4'b0001, "rst_first_grant");
        push(0);
        @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);
        #1 chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
